// File: rtl/core_int_ctrl.sv
// ---------------------------------------------------------------------------------------------
// core_int_ctrl
//
// Interrupt controller sitting at the core's interrupt handshake. It synchronises and latches
// peripheral requests, arbitrates them by a two-level priority scheme with nesting, and
// presents a 3-bit vector to the core. IE, IP and IFLG are exposed as SFRs on the core's SFR bus.
//
// Ports:
//   int_clock_i     core clock, all state updates on posedge
//   int_reset_i     asynchronous active-high reset
//   int_src_i       raw peripheral requests (asynchronous, active high)
//   int_sfr_addr_i  SFR address
//   int_sfr_data_i  SFR write data
//   int_sfr_rd_i_b  SFR read strobe (active low)
//   int_sfr_wr_i_b  SFR write strobe (active low)
//   int_sfr_data_o  SFR read data, 8'h00 when not selected
//   int_sfr_sel_o   address hit on an owned SFR while either strobe is low
//   int_rdy_i       core accepted the presented vector (one-cycle pulse)
//   int_na_i        core executed RETI (one-cycle pulse)
//   int_req_o       interrupt request to the core
//   int_vect_o      vector of the requested source
//   int_active_o    in-service bits, [1] high level, [0] low level
//
// Optional feature macro: INT_LEVEL_TRIG_EN adds the IT register at SFR_IT_ADDR, which makes
// selected sources level-triggered. Without it every source is edge-triggered.
// ---------------------------------------------------------------------------------------------
module core_int_ctrl #(
    parameter int unsigned NUM_SRC       = 5,
    parameter logic [7:0]  SFR_IE_ADDR   = 8'hA8,
    parameter logic [7:0]  SFR_IP_ADDR   = 8'hB8,
    parameter logic [7:0]  SFR_IFLG_ADDR = 8'h88
`ifdef INT_LEVEL_TRIG_EN
    ,
    parameter logic [7:0]  SFR_IT_ADDR   = 8'h89
`endif
) (
    input  logic               int_clock_i,
    input  logic               int_reset_i,
    input  logic [NUM_SRC-1:0] int_src_i,
    input  logic [7:0]         int_sfr_addr_i,
    input  logic [7:0]         int_sfr_data_i,
    input  logic               int_sfr_rd_i_b,
    input  logic               int_sfr_wr_i_b,
    output logic [7:0]         int_sfr_data_o,
    output logic               int_sfr_sel_o,
    input  logic               int_rdy_i,
    input  logic               int_na_i,
    output logic               int_req_o,
    output logic [2:0]         int_vect_o,
    output logic [1:0]         int_active_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_sync3;
    logic [NUM_SRC-1:0] r_flag;
    logic [NUM_SRC-1:0] r_ie;
    logic               r_ea;
    logic [NUM_SRC-1:0] r_ip;
    logic [1:0]         r_state;
    logic               r_req;
    logic [2:0]         r_vect;
    logic               r_lvl;
    logic [1:0]         r_active;
`ifdef INT_LEVEL_TRIG_EN
    logic [NUM_SRC-1:0] r_it;
`endif

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_flag_d;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_elig_hi;
    logic [NUM_SRC-1:0] w_elig_lo;
    logic [NUM_SRC-1:0] w_vect_oh;
    logic [2:0]         w_hi_idx;
    logic [2:0]         w_lo_idx;
    logic               w_win_valid;
    logic [2:0]         w_win_idx;
    logic               w_win_lvl;
    logic               w_vect_elig;
    logic               w_ack;
    logic [1:0]         w_state_d;
    logic               w_req_d;
    logic [2:0]         w_vect_d;
    logic               w_lvl_d;
    logic [1:0]         w_active_d;
    logic               w_hit_ie;
    logic               w_hit_ip;
    logic               w_hit_iflg;
    logic               w_hit;
    logic               w_wr_ie;
    logic               w_wr_ip;
    logic               w_wr_iflg;
    logic [7:0]         w_rd_data;
    logic               w_unused_data;
`ifdef INT_LEVEL_TRIG_EN
    logic               w_hit_it;
    logic               w_wr_it;
`endif

    // Upper data bits are only meaningful for some registers.
    assign w_unused_data = ^int_sfr_data_i;

    // ------------------------------------------------------------------
    // SFR decode
    // ------------------------------------------------------------------
    assign w_hit_ie   = (int_sfr_addr_i == SFR_IE_ADDR);
    assign w_hit_ip   = (int_sfr_addr_i == SFR_IP_ADDR);
    assign w_hit_iflg = (int_sfr_addr_i == SFR_IFLG_ADDR);
`ifdef INT_LEVEL_TRIG_EN
    assign w_hit_it   = (int_sfr_addr_i == SFR_IT_ADDR);
    assign w_hit      = w_hit_ie | w_hit_ip | w_hit_iflg | w_hit_it;
    assign w_wr_it    = w_hit_it & ~int_sfr_wr_i_b;
`else
    assign w_hit      = w_hit_ie | w_hit_ip | w_hit_iflg;
`endif

    assign w_wr_ie   = w_hit_ie & ~int_sfr_wr_i_b;
    assign w_wr_ip   = w_hit_ip & ~int_sfr_wr_i_b;
    assign w_wr_iflg = w_hit_iflg & ~int_sfr_wr_i_b;

    assign int_sfr_sel_o = w_hit & (~int_sfr_rd_i_b | ~int_sfr_wr_i_b);

    always_comb begin
        w_rd_data = 8'h00;
        if (!int_sfr_rd_i_b) begin
            if (w_hit_ie) begin
                w_rd_data[NUM_SRC-1:0] = r_ie;
                w_rd_data[7]           = r_ea;
            end else if (w_hit_ip) begin
                w_rd_data[NUM_SRC-1:0] = r_ip;
            end else if (w_hit_iflg) begin
                w_rd_data[NUM_SRC-1:0] = r_flag;
`ifdef INT_LEVEL_TRIG_EN
            end else if (w_hit_it) begin
                w_rd_data[NUM_SRC-1:0] = r_it;
`endif
            end
        end
    end

    assign int_sfr_data_o = w_rd_data;

    // ------------------------------------------------------------------
    // Input capture: 2-flop synchroniser plus rising-edge detect
    // ------------------------------------------------------------------
    assign w_edge = r_sync2 & ~r_sync3;

    // One-hot of the latched vector, used for withdrawal check and ACK clear.
    always_comb begin
        w_vect_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_vect_oh[i] = (r_vect == 3'(i));
        end
    end

    assign w_ack = (r_state == StReq) & int_rdy_i;

    // Order matters: SFR clear, then ACK clear, then edge set so a new edge always survives.
    always_comb begin
        w_flag_d = r_flag;
        if (w_wr_iflg) begin
            w_flag_d = w_flag_d & int_sfr_data_i[NUM_SRC-1:0];
        end
        if (w_ack) begin
            w_flag_d = w_flag_d & ~w_vect_oh;
        end
        w_flag_d = w_flag_d | w_edge;
`ifdef INT_LEVEL_TRIG_EN
        // Level-triggered sources simply mirror the synchronised input.
        w_flag_d = (w_flag_d & ~r_it) | (r_sync2 & r_it);
`endif
    end

    // ------------------------------------------------------------------
    // Eligibility and arbitration
    // ------------------------------------------------------------------
    assign w_elig    = r_flag & r_ie & {NUM_SRC{r_ea}};
    assign w_elig_hi = w_elig & r_ip;
    assign w_elig_lo = w_elig & ~r_ip;

    // Lowest index wins within a level: scan downwards so the last hit is the lowest.
    always_comb begin
        w_hi_idx = 3'd0;
        w_lo_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig_hi[i]) begin
                w_hi_idx = 3'(i);
            end
            if (w_elig_lo[i]) begin
                w_lo_idx = 3'(i);
            end
        end
    end

    // A request is only allowed when its level is above the current service level.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = 3'd0;
        w_win_lvl   = 1'b0;
        if (|w_elig_hi) begin
            w_win_idx   = w_hi_idx;
            w_win_lvl   = 1'b1;
            w_win_valid = ~r_active[1];
        end else if (|w_elig_lo) begin
            w_win_idx   = w_lo_idx;
            w_win_lvl   = 1'b0;
            w_win_valid = (r_active == 2'b00);
        end
    end

    assign w_vect_elig = |(w_vect_oh & w_elig);

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_vect_d  = r_vect;
        w_lvl_d   = r_lvl;
        case (r_state)
            StIdle: begin
                if (w_win_valid) begin
                    w_vect_d  = w_win_idx;
                    w_lvl_d   = w_win_lvl;
                    w_req_d   = 1'b1;
                    w_state_d = StReq;
                end
            end
            StReq: begin
                // Acceptance has precedence over a same-cycle withdrawal.
                if (int_rdy_i) begin
                    w_req_d   = 1'b0;
                    w_state_d = StAck;
                end else if (!w_vect_elig) begin
                    w_req_d   = 1'b0;
                    w_state_d = StIdle;
                end
            end
            StAck: begin
                w_req_d   = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_req_d   = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    // RETI clears the highest in-service bit first, then an accept sets its level.
    always_comb begin
        w_active_d = r_active;
        if (int_na_i) begin
            if (r_active[1]) begin
                w_active_d[1] = 1'b0;
            end else if (r_active[0]) begin
                w_active_d[0] = 1'b0;
            end
        end
        if (w_ack) begin
            if (r_lvl) begin
                w_active_d[1] = 1'b1;
            end else begin
                w_active_d[0] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge int_clock_i or posedge int_reset_i) begin
        if (int_reset_i) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync3  <= '0;
            r_flag   <= '0;
            r_ie     <= '0;
            r_ea     <= 1'b0;
            r_ip     <= '0;
            r_state  <= StIdle;
            r_req    <= 1'b0;
            r_vect   <= 3'd0;
            r_lvl    <= 1'b0;
            r_active <= 2'b00;
        end else begin
            r_sync1  <= int_src_i;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_flag   <= w_flag_d;
            if (w_wr_ie) begin
                r_ie <= int_sfr_data_i[NUM_SRC-1:0];
                r_ea <= int_sfr_data_i[7];
            end
            if (w_wr_ip) begin
                r_ip <= int_sfr_data_i[NUM_SRC-1:0];
            end
            r_state  <= w_state_d;
            r_req    <= w_req_d;
            r_vect   <= w_vect_d;
            r_lvl    <= w_lvl_d;
            r_active <= w_active_d;
        end
    end

`ifdef INT_LEVEL_TRIG_EN
    always_ff @(posedge int_clock_i or posedge int_reset_i) begin
        if (int_reset_i) begin
            r_it <= '0;
        end else if (w_wr_it) begin
            r_it <= int_sfr_data_i[NUM_SRC-1:0];
        end
    end
`endif

    assign int_req_o    = r_req;
    assign int_vect_o   = r_vect;
    assign int_active_o = r_active;

endmodule

// File: tb/tb_core_int_ctrl.sv
module tb_core_int_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] src;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rd_b;
    logic       wr_b;
    logic [7:0] rdata;
    logic       sel;
    logic       rdy;
    logic       na;
    logic       req;
    logic [2:0] vect;
    logic [1:0] active;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rd_v;
    logic       sel_v;

    core_int_ctrl #(
        .NUM_SRC(5)
    ) dut (
        .int_clock_i   (clk),
        .int_reset_i   (rst),
        .int_src_i     (src),
        .int_sfr_addr_i(addr),
        .int_sfr_data_i(wdata),
        .int_sfr_rd_i_b(rd_b),
        .int_sfr_wr_i_b(wr_b),
        .int_sfr_data_o(rdata),
        .int_sfr_sel_o (sel),
        .int_rdy_i     (rdy),
        .int_na_i      (na),
        .int_req_o     (req),
        .int_vect_o    (vect),
        .int_active_o  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_b  = 1'b0;
        tick();
        wr_b  = 1'b1;
    endtask

    task automatic sfr_read(input logic [7:0] a, output logic [7:0] d, output logic s);
        addr = a;
        rd_b = 1'b0;
        #1;
        d    = rdata;
        s    = sel;
        rd_b = 1'b1;
    endtask

    task automatic cleanup();
        src = '0;
        rdy = 1'b0;
        sfr_write(8'hA8, 8'h00);
        sfr_write(8'hB8, 8'h00);
`ifdef INT_LEVEL_TRIG_EN
        sfr_write(8'h89, 8'h00);
`endif
        na = 1'b1;
        ticks(2);
        na = 1'b0;
        sfr_write(8'h88, 8'h00);
        ticks(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
        n_checks++;
        if (req !== 1'b0 || vect !== 3'd0 || active !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b vect=%0d active=%b, required 0/0/00",
                     req, vect, active);
        end
        n_checks++;
        if (rdata !== 8'h00 || sel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sfr_idle: data=%h sel=%b, required 00/0", rdata, sel);
        end
    endtask

    task automatic test_sfr();
        sfr_write(8'hA8, 8'hFF);
        sfr_read(8'hA8, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h9F || sel_v !== 1'b1) begin
            n_fail++;
            $display("FAIL ie_readback: data=%h sel=%b, required 9f/1", rd_v, sel_v);
        end
        sfr_write(8'hB8, 8'hFF);
        sfr_read(8'hB8, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h1F) begin
            n_fail++;
            $display("FAIL ip_readback: data=%h, required 1f", rd_v);
        end
        addr = 8'hA8;
        #1;
        n_checks++;
        if (sel !== 1'b0 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL sel_no_strobe: sel=%b data=%h, required 0/00", sel, rdata);
        end
        sfr_read(8'h89, rd_v, sel_v);
`ifdef INT_LEVEL_TRIG_EN
        sfr_write(8'h89, 8'hFF);
        sfr_read(8'h89, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h1F || sel_v !== 1'b1) begin
            n_fail++;
            $display("FAIL it_readback: data=%h sel=%b, required 1f/1", rd_v, sel_v);
        end
`else
        n_checks++;
        if (rd_v !== 8'h00 || sel_v !== 1'b0) begin
            n_fail++;
            $display("FAIL it_absent: data=%h sel=%b, required 00/0", rd_v, sel_v);
        end
`endif
        cleanup();
    endtask

    task automatic test_basic();
        sfr_write(8'hA8, 8'h81);
        src[0] = 1'b1;
        ticks(3);
        n_checks++;
        if (req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_req_early: req=%b at cycle 3, required 0", req);
        end
        tick();
        n_checks++;
        if (req !== 1'b1 || vect !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_req: req=%b vect=%0d at cycle 4, required 1/0", req, vect);
        end
        sfr_read(8'h88, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h01) begin
            n_fail++;
            $display("FAIL basic_flag_pending: iflg=%h, required 01", rd_v);
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
        sfr_read(8'h88, rd_v, sel_v);
        n_checks++;
        if (active !== 2'b01 || req !== 1'b0 || rd_v !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_ack: active=%b req=%b iflg=%h, required 01/0/00",
                     active, req, rd_v);
        end
        cleanup();
    endtask

    task automatic test_priority();
        sfr_write(8'hA8, 8'h9F);
        sfr_write(8'hB8, 8'h00);
        src = 5'b10100;
        ticks(4);
        n_checks++;
        if (req !== 1'b1 || vect !== 3'd2) begin
            n_fail++;
            $display("FAIL prio_index_tie: req=%b vect=%0d, required 1/2", req, vect);
        end
        cleanup();
        sfr_write(8'hA8, 8'h9F);
        sfr_write(8'hB8, 8'h10);
        src = 5'b10100;
        ticks(4);
        n_checks++;
        if (req !== 1'b1 || vect !== 3'd4) begin
            n_fail++;
            $display("FAIL prio_high_wins: req=%b vect=%0d, required 1/4", req, vect);
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        ticks(4);
        n_checks++;
        if (active !== 2'b10 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_low_blocked: active=%b req=%b, required 10/0", active, req);
        end
        na = 1'b1;
        tick();
        na = 1'b0;
        tick();
        n_checks++;
        if (active !== 2'b00 || req !== 1'b1 || vect !== 3'd2) begin
            n_fail++;
            $display("FAIL prio_low_after_reti: active=%b req=%b vect=%0d, required 00/1/2",
                     active, req, vect);
        end
        cleanup();
    endtask

    task automatic test_nesting();
        sfr_write(8'hA8, 8'h8A);
        sfr_write(8'hB8, 8'h08);
        src[1] = 1'b1;
        ticks(4);
        n_checks++;
        if (req !== 1'b1 || vect !== 3'd1) begin
            n_fail++;
            $display("FAIL nest_low_req: req=%b vect=%0d, required 1/1", req, vect);
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
        src[3] = 1'b1;
        ticks(4);
        n_checks++;
        if (req !== 1'b1 || vect !== 3'd3 || active !== 2'b01) begin
            n_fail++;
            $display("FAIL nest_preempt_req: req=%b vect=%0d active=%b, required 1/3/01",
                     req, vect, active);
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        n_checks++;
        if (active !== 2'b11) begin
            n_fail++;
            $display("FAIL nest_both_active: active=%b, required 11", active);
        end
        na = 1'b1;
        tick();
        n_checks++;
        if (active !== 2'b01) begin
            n_fail++;
            $display("FAIL nest_reti_high: active=%b, required 01", active);
        end
        tick();
        n_checks++;
        if (active !== 2'b00) begin
            n_fail++;
            $display("FAIL nest_reti_low: active=%b, required 00", active);
        end
        tick();
        na = 1'b0;
        n_checks++;
        if (active !== 2'b00 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL nest_reti_idle: active=%b req=%b, required 00/0", active, req);
        end
        cleanup();
    endtask

    task automatic test_withdrawal();
        sfr_write(8'hA8, 8'h81);
        src[0] = 1'b1;
        ticks(4);
        n_checks++;
        if (req !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_req: req=%b, required 1", req);
        end
        sfr_write(8'hA8, 8'h80);
        tick();
        n_checks++;
        if (req !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_drop: req=%b, required 0", req);
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
        sfr_read(8'h88, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h01 || active !== 2'b00) begin
            n_fail++;
            $display("FAIL wd_no_ack: iflg=%h active=%b, required 01/00", rd_v, active);
        end
        cleanup();
    endtask

    task automatic test_collision();
        src[1] = 1'b1;
        ticks(2);
        // IFLG clear sampled on the same edge that sets flag1
        sfr_write(8'h88, 8'h00);
        sfr_read(8'h88, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h02) begin
            n_fail++;
            $display("FAIL collision_set_wins: iflg=%h, required 02", rd_v);
        end
        sfr_write(8'h88, 8'h00);
        sfr_read(8'h88, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h00) begin
            n_fail++;
            $display("FAIL iflg_write_clear: iflg=%h, required 00", rd_v);
        end
        cleanup();
`ifdef INT_LEVEL_TRIG_EN
        sfr_write(8'h89, 8'h02);
        sfr_write(8'hA8, 8'h82);
        src[1] = 1'b1;
        ticks(4);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
        na = 1'b1;
        tick();
        na = 1'b0;
        tick();
        n_checks++;
        if (req !== 1'b1 || vect !== 3'd1) begin
            n_fail++;
            $display("FAIL level_reassert: req=%b vect=%0d, required 1/1", req, vect);
        end
        cleanup();
`endif
    endtask

    task automatic test_reset_mid_req();
        sfr_write(8'hA8, 8'h81);
        src[0] = 1'b1;
        ticks(4);
        n_checks++;
        if (req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_setup: req=%b, required 1", req);
        end
        #2;
        rst = 1'b1;
        #1;
        sfr_read(8'hA8, rd_v, sel_v);
        n_checks++;
        if (req !== 1'b0 || active !== 2'b00 || rd_v !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_req: req=%b active=%b ie=%h, required 0/00/00",
                     req, active, rd_v);
        end
        src = '0;
        tick();
        rst = 1'b0;
        ticks(4);
        sfr_read(8'h88, rd_v, sel_v);
        n_checks++;
        if (rd_v !== 8'h00 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags_gone: iflg=%h req=%b, required 00/0", rd_v, req);
        end
        cleanup();
    endtask

    initial begin
        rst   = 1'b1;
        src   = '0;
        addr  = 8'h00;
        wdata = 8'h00;
        rd_b  = 1'b1;
        wr_b  = 1'b1;
        rdy   = 1'b0;
        na    = 1'b0;
        test_reset();
        test_sfr();
        test_basic();
        test_priority();
        test_nesting();
        test_withdrawal();
        test_collision();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
